qacc_sm: RTL and testbench
==========================

QACC_SM -- requirements
Module: qacc_sm

Interface
REQ-001 Parameter Q, default 16: number of fractional bits in every data word.
REQ-002 Parameter N, default 32: word width; format is sign-magnitude, bit N-1 is the sign and bits N-2:0 are the magnitude.
REQ-003 i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  synchronous, active-low reset, sampled on the i_clk rising edge.
REQ-005 i_valid  input  1  upstream product word present on i_data.
REQ-006 i_data  input  N  sign-magnitude Q-format term, typically a multiplier-stage output.
REQ-007 i_last  input  1  qualifies i_data as the final term of the current vector.
REQ-008 o_ready  output  1  block accepts a term this cycle.
REQ-009 o_valid  output  1  o_result holds a completed vector sum.
REQ-010 i_ready  input  1  downstream consumes o_result.
REQ-011 o_result  output  N  sign-magnitude Q-format accumulated sum.
REQ-012 o_overflow  output  1  sticky flag: saturation occurred within the reported vector.
REQ-013 o_count  output  8  number of terms in the reported vector, saturating at 255.

Function
REQ-014 A term SHALL be accepted only on a cycle where i_valid=1 and o_ready=1; i_data is ignored otherwise.
REQ-015 The block SHALL have two states, ACC (o_ready=1, o_valid=0) and DONE (o_ready=0, o_valid=1).
REQ-016 ACC->DONE SHALL occur on the edge that accepts a term with i_last=1; DONE->ACC SHALL occur on the edge where i_ready=1.
REQ-017 Latency: o_valid SHALL assert on the cycle after the i_last term is accepted, and o_result SHALL include that term.
REQ-018 In DONE, o_result, o_overflow and o_count SHALL remain stable until the term is consumed.
REQ-019 On leaving DONE, the accumulator, overflow flag and count SHALL clear to 0, so the next accepted term starts a new vector.
REQ-020 Same-sign addition: magnitudes add and the sign is kept.
REQ-021 Opposite-sign addition: the smaller magnitude is subtracted from the larger, and the sign of the larger is taken.
REQ-022 Equal magnitudes of opposite sign SHALL give +0 (0x00000000).
REQ-023 Negative zero, on input or as a result, SHALL be treated and stored as +0.
REQ-024 A same-sign magnitude sum exceeding 2^(N-1)-1 SHALL saturate the magnitude to 2^(N-1)-1, keep the sign, and set the overflow flag.
REQ-025 Subsequent terms SHALL operate on the saturated value normally; the overflow flag stays set until the vector is consumed.
REQ-026 The count SHALL increment per accepted term and hold at 255.
REQ-027 A single-term vector (i_last on the first term) SHALL report that term, normalised per REQ-023, with o_count=1.
REQ-028 No combinational path SHALL exist from i_valid/i_data to o_ready; o_ready depends on state only.

Reset
REQ-029 With i_rst_n=0 at a rising edge, the next state SHALL be: ACC, o_ready=1, o_valid=0, o_result=0, o_overflow=0, o_count=0.
REQ-030 Reset mid-vector or in DONE SHALL discard all partial or pending results with no output.
REQ-031 A term presented during a reset cycle SHALL NOT be accepted.

Verification
REQ-032 Accept 0x00018000 (1.5), 0x80008000 (-0.5, last) -> next cycle o_valid=1, o_result=0x00010000, o_count=2, o_overflow=0.
REQ-033 Accept 0x7FFF0000, then 0x00020000 (last) -> o_result=0x7FFFFFFF, o_overflow=1; add a third term 0x80010000 before last -> o_result=0x7FFEFFFF, o_overflow still 1.
REQ-034 Accept 0x00010000, 0x80010000 (last) -> o_result=0x00000000, never 0x80000000; a single term 0x80000000 (last) -> o_result=0x00000000, o_count=1.
REQ-035 Hold i_ready=0 for 5 cycles in DONE while i_valid=1 -> o_ready=0, outputs stable, no term lost; release -> the next vector starts from 0.
REQ-036 Drop i_rst_n after 3 accepted terms -> outputs are at reset values; the following vector 0x00008000 (last) -> o_result=0x00008000, o_count=1.
REQ-037 Stream 300 terms of 0x00000001 -> o_count=255, o_result=0x0000012C.

Source files
------------

// File: rtl/qacc_sm.sv
// Sign-magnitude Q-format vector accumulator with valid/ready handshakes.
// Terms are summed with magnitude saturation until i_last, then the sum is held until consumed.
module qacc_sm #(
  parameter int Q = 16,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [N-1:0] i_data,
  input  logic         i_last,
  output logic         o_ready,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_overflow,
  output logic [7:0]   o_count
);

  typedef enum logic {ACC, DONE} state_t;

  localparam logic [N-2:0] MAX_MAG = '1;

  // Q only places the binary point; sign-magnitude addition does not depend on it.
  if (Q >= N) begin : g_q_exceeds_width
  end

  state_t       r_state;
  logic         r_sign;
  logic [N-2:0] r_mag;
  logic         r_ovf;
  logic [7:0]   r_cnt;

  logic [N-2:0] w_in_mag;
  logic         w_in_sign;
  logic [N-1:0] w_sum;
  logic         w_acc_ge;
  logic [N-2:0] w_diff;
  logic [N-2:0] w_nxt_mag;
  logic         w_nxt_sign_raw;
  logic         w_nxt_sign;
  logic         w_sat;

  // A zero magnitude is forced positive so -0 never enters or leaves the accumulator.
  always_comb begin
    w_in_mag       = i_data[N-2:0];
    w_in_sign      = i_data[N-1] & (|w_in_mag);
    w_sum          = {1'b0, r_mag} + {1'b0, w_in_mag};
    w_acc_ge       = (r_mag >= w_in_mag);
    w_diff         = w_acc_ge ? (r_mag - w_in_mag) : (w_in_mag - r_mag);
    w_nxt_mag      = '0;
    w_nxt_sign_raw = 1'b0;
    w_sat          = 1'b0;
    if (r_sign == w_in_sign) begin
      w_nxt_sign_raw = r_sign;
      if (w_sum[N-1]) begin
        w_nxt_mag = MAX_MAG;
        w_sat     = 1'b1;
      end else begin
        w_nxt_mag = w_sum[N-2:0];
      end
    end else begin
      w_nxt_mag      = w_diff;
      w_nxt_sign_raw = w_acc_ge ? r_sign : w_in_sign;
    end
    w_nxt_sign = w_nxt_sign_raw & (|w_nxt_mag);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ACC;
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        ACC: begin
          if (i_valid) begin
            r_sign <= w_nxt_sign;
            r_mag  <= w_nxt_mag;
            r_ovf  <= r_ovf | w_sat;
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            if (i_last) r_state <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            r_state <= ACC;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= 8'd0;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  assign o_ready    = (r_state == ACC);
  assign o_valid    = (r_state == DONE);
  assign o_result   = {r_sign, r_mag};
  assign o_overflow = r_ovf;
  assign o_count    = r_cnt;

endmodule

// File: tb/tb_qacc_sm.sv
// Bench for qacc_sm: a signed-integer reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_qacc_sm;
  localparam int N = 32;
  localparam longint MAXV = 64'sh0000_0000_7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [N-1:0]  data = '0;
  logic          last = 1'b0;
  logic          rdy = 1'b0;
  logic          o_ready;
  logic          o_valid;
  logic [N-1:0]  o_result;
  logic          o_overflow;
  logic [7:0]    o_count;

  int checks = 0;
  int failures = 0;
  bit cmpEn = 1'b0;

  longint mSum = 0;
  bit     mOvf = 1'b0;
  bit     mDone = 1'b0;
  int     mCnt = 0;

  always #5 clk = ~clk;

  qacc_sm #(.Q(16), .N(N)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_valid(valid),
    .i_data(data),
    .i_last(last),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .i_ready(rdy),
    .o_result(o_result),
    .o_overflow(o_overflow),
    .o_count(o_count)
  );

  function automatic longint toInt(logic [31:0] w);
    longint m;
    m = longint'(w[30:0]);
    return w[31] ? -m : m;
  endfunction

  function automatic logic [31:0] toSm(longint v);
    if (v < 0) return {1'b1, 31'(-v)};
    return {1'b0, 31'(v)};
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic r, logic v, logic [31:0] d, logic l, logic dr);
    rst_n = r;
    valid = v;
    data  = d;
    last  = l;
    rdy   = dr;
    @(posedge clk);
    #2;
  endtask

  // Reference model: the vector sum is a plain integer clamped to the representable range.
  always @(posedge clk) begin
    if (!rst_n) begin
      mDone = 1'b0; mSum = 0; mOvf = 1'b0; mCnt = 0;
    end else if (!mDone) begin
      if (valid) begin
        mSum = mSum + toInt(data);
        if (mSum > MAXV) begin mSum = MAXV; mOvf = 1'b1; end
        else if (mSum < -MAXV) begin mSum = -MAXV; mOvf = 1'b1; end
        mCnt = (mCnt < 255) ? mCnt + 1 : 255;
        if (last) mDone = 1'b1;
      end
    end else if (rdy) begin
      mDone = 1'b0; mSum = 0; mOvf = 1'b0; mCnt = 0;
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("m_ready", {31'd0, o_ready}, {31'd0, !mDone});
      checkOutput("m_valid", {31'd0, o_valid}, {31'd0, mDone});
      if (mDone) begin
        checkOutput("m_result", o_result, toSm(mSum));
        checkOutput("m_overflow", {31'd0, o_overflow}, {31'd0, mOvf});
        checkOutput("m_count", {24'd0, o_count}, 32'(mCnt));
      end
    end
  end

  task automatic checkDone(string tag, logic [31:0] res, logic ovf, logic [7:0] cnt);
    checkOutput({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    checkOutput({tag, "_result"}, o_result, res);
    checkOutput({tag, "_overflow"}, {31'd0, o_overflow}, {31'd0, ovf});
    checkOutput({tag, "_count"}, {24'd0, o_count}, {24'd0, cnt});
  endtask

  task automatic checkReset(string tag);
    checkOutput({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    checkOutput({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    checkOutput({tag, "_result"}, o_result, 32'd0);
    checkOutput({tag, "_overflow"}, {31'd0, o_overflow}, 32'd0);
    checkOutput({tag, "_count"}, {24'd0, o_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [30:0] mag;

    applyStimulus(0, 1, 32'h0001_0000, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkReset("reset");
    cmpEn = 1'b1;

    applyStimulus(1, 1, 32'h0001_8000, 0, 0);
    applyStimulus(1, 1, 32'h8000_8000, 1, 0);
    checkDone("mixed", 32'h0001_0000, 0, 8'd2);
    checkOutput("mixed_ready", {31'd0, o_ready}, 32'd0);

    // Hold the result with a pending upstream term; it must not be taken.
    held = o_result;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 32'h0003_0000, 1, 0);
      checkOutput("hold_ready", {31'd0, o_ready}, 32'd0);
      checkOutput("hold_result", o_result, held);
      checkOutput("hold_count", {24'd0, o_count}, 32'd2);
    end
    applyStimulus(1, 1, 32'h0003_0000, 1, 1);
    checkOutput("release_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("release_result", o_result, 32'd0);
    applyStimulus(1, 1, 32'h0003_0000, 1, 0);
    checkDone("after_hold", 32'h0003_0000, 0, 8'd1);
    applyStimulus(1, 0, 0, 0, 1);

    applyStimulus(1, 1, 32'h7FFF_0000, 0, 0);
    applyStimulus(1, 1, 32'h0002_0000, 1, 0);
    checkDone("sat", 32'h7FFF_FFFF, 1, 8'd2);
    applyStimulus(1, 0, 0, 0, 1);

    applyStimulus(1, 1, 32'h7FFF_0000, 0, 0);
    applyStimulus(1, 1, 32'h0002_0000, 0, 0);
    applyStimulus(1, 1, 32'h8001_0000, 1, 0);
    checkDone("sat_then_sub", 32'h7FFE_FFFF, 1, 8'd3);
    applyStimulus(1, 0, 0, 0, 1);

    applyStimulus(1, 1, 32'h0001_0000, 0, 0);
    applyStimulus(1, 1, 32'h8001_0000, 1, 0);
    checkDone("cancel", 32'h0000_0000, 0, 8'd2);
    applyStimulus(1, 0, 0, 0, 1);

    applyStimulus(1, 1, 32'h8000_0000, 1, 0);
    checkDone("negzero", 32'h0000_0000, 0, 8'd1);
    applyStimulus(1, 0, 0, 0, 1);

    applyStimulus(1, 1, 32'h8000_0000, 0, 0);
    applyStimulus(1, 1, 32'h8000_0005, 1, 0);
    checkDone("neg_sum", 32'h8000_0005, 0, 8'd2);
    applyStimulus(1, 0, 0, 0, 1);

    applyStimulus(1, 1, 32'h0001_0000, 0, 0);
    applyStimulus(1, 1, 32'h0002_0000, 0, 0);
    applyStimulus(1, 1, 32'h0003_0000, 0, 0);
    applyStimulus(0, 1, 32'h0005_0000, 1, 1);
    checkReset("midreset");
    applyStimulus(1, 1, 32'h0000_8000, 1, 0);
    checkDone("post_reset", 32'h0000_8000, 0, 8'd1);
    applyStimulus(1, 0, 0, 0, 1);

    for (int i = 0; i < 299; i++) applyStimulus(1, 1, 32'h0000_0001, 0, 0);
    applyStimulus(1, 1, 32'h0000_0001, 1, 0);
    checkDone("long", 32'h0000_012C, 0, 8'd255);
    applyStimulus(1, 0, 0, 0, 1);

    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0: mag = 31'd0;
        1: mag = 31'($urandom_range(0, 32'h0003_FFFF));
        2: mag = 31'($urandom);
        default: mag = 31'h7FFF_FFFF - 31'($urandom_range(0, 32'h0003_FFFF));
      endcase
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                    {1'($urandom_range(0, 1)), mag}, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 1) == 1);
    end
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
